// File: rtl/cgia_bus_arbiter.sv
// rtl/cgia_bus_arbiter.sv - two-master Wishbone arbiter for the CGIA video memory port
// The fetcher (V) has priority; per-grant ack budgets bound how long either master can hold the bus.
module cgia_bus_arbiter #(
  parameter int VID_BURST_MAX = 8,
  parameter int CPU_BURST_MAX = 1
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        vid_cyc_i,
  input  logic        vid_stb_i,
  input  logic [22:0] vid_adr_i,
  output logic        vid_ack_o,
  output logic [15:0] vid_dat_o,
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [1:0]  cpu_sel_i,
  input  logic [22:0] cpu_adr_i,
  input  logic [15:0] cpu_dat_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_dat_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [1:0]  sel_o,
  output logic [22:0] adr_o,
  output logic [15:0] dat_o,
  input  logic        ack_i,
  input  logic [15:0] dat_i,
  output logic        gnt_vid_o,
  output logic        gnt_cpu_o
);

  typedef enum logic [1:0] {S_IDLE, S_GNT_VID, S_GNT_CPU} state_t;

  localparam logic [7:0] VID_MAX = 8'(VID_BURST_MAX);
  localparam logic [7:0] CPU_MAX = 8'(CPU_BURST_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_max;
  logic       w_spent;

  assign w_cnt_max = (r_state == S_GNT_CPU) ? CPU_MAX : VID_MAX;
  // The ack this cycle uses up the budget; also true once saturated, so a late contender still wins.
  assign w_spent   = ({1'b0, r_cnt} + 9'd1) >= {1'b0, w_cnt_max};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= 8'd0;
      else if (ack_i && (r_state != S_IDLE) && (r_cnt < w_cnt_max))
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (vid_cyc_i)      w_next = S_GNT_VID;
        else if (cpu_cyc_i) w_next = S_GNT_CPU;
      end
      S_GNT_VID: begin
        if (!vid_cyc_i)                       w_next = cpu_cyc_i ? S_GNT_CPU : S_IDLE;
        else if (ack_i && w_spent && cpu_cyc_i) w_next = S_GNT_CPU;
      end
      S_GNT_CPU: begin
        if (!cpu_cyc_i)                       w_next = vid_cyc_i ? S_GNT_VID : S_IDLE;
        else if (ack_i && w_spent && vid_cyc_i) w_next = S_GNT_VID;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign gnt_vid_o = (r_state == S_GNT_VID);
  assign gnt_cpu_o = (r_state == S_GNT_CPU);

  always_comb begin
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    sel_o = 2'b00;
    adr_o = 23'd0;
    dat_o = 16'd0;
    if (gnt_vid_o) begin
      cyc_o = vid_cyc_i;
      stb_o = vid_stb_i;
      sel_o = 2'b11;
      adr_o = vid_adr_i;
    end else if (gnt_cpu_o) begin
      cyc_o = cpu_cyc_i;
      stb_o = cpu_stb_i;
      we_o  = cpu_we_i;
      sel_o = cpu_sel_i;
      adr_o = cpu_adr_i;
      dat_o = cpu_dat_i;
    end
  end

  assign vid_ack_o = ack_i & gnt_vid_o;
  assign cpu_ack_o = ack_i & gnt_cpu_o;
  assign vid_dat_o = dat_i;
  assign cpu_dat_o = dat_i;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// tb/tb_cgia_bus_arbiter.sv - directed self-checking bench for cgia_bus_arbiter
module tb_cgia_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        vid_cyc_i, vid_stb_i;
  logic [22:0] vid_adr_i;
  logic        vid_ack_o;
  logic [15:0] vid_dat_o;
  logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [1:0]  cpu_sel_i;
  logic [22:0] cpu_adr_i;
  logic [15:0] cpu_dat_i;
  logic        cpu_ack_o;
  logic [15:0] cpu_dat_o;
  logic        cyc_o, stb_o, we_o;
  logic [1:0]  sel_o;
  logic [22:0] adr_o;
  logic [15:0] dat_o;
  logic        ack_i;
  logic [15:0] dat_i;
  logic        gnt_vid_o, gnt_cpu_o;

  int checks   = 0;
  int failures = 0;
  int acks;
  int left_vid;

  always #5 clk_i = ~clk_i;

  cgia_bus_arbiter #(.VID_BURST_MAX(8), .CPU_BURST_MAX(1)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .vid_cyc_i(vid_cyc_i), .vid_stb_i(vid_stb_i), .vid_adr_i(vid_adr_i),
    .vid_ack_o(vid_ack_o), .vid_dat_o(vid_dat_o),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
    .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i),
    .gnt_vid_o(gnt_vid_o), .gnt_cpu_o(gnt_cpu_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ni  = 1'b0;
    vid_cyc_i = 1'b1; vid_stb_i = 1'b1; vid_adr_i = 23'h7F8000;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b1;
    cpu_sel_i = 2'b01; cpu_adr_i = 23'h000010; cpu_dat_i = 16'hBEEF;
    ack_i = 1'b1; dat_i = 16'h1234;

    // reset held with both masters requesting
    repeat (2) @(negedge clk_i);
    chk("rst_cyc_o", 32'(cyc_o), 32'd0);
    chk("rst_gnt_vid", 32'(gnt_vid_o), 32'd0);
    chk("rst_gnt_cpu", 32'(gnt_cpu_o), 32'd0);
    chk("rst_vid_ack", 32'(vid_ack_o), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
    chk("rst_adr_o", 32'(adr_o), 32'd0);

    // release: simultaneous request resolves to V one cycle later
    ack_i = 1'b0;
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("sim_gnt_vid", 32'(gnt_vid_o), 32'd1);
    chk("sim_gnt_cpu", 32'(gnt_cpu_o), 32'd0);
    chk("vid_cyc_o", 32'(cyc_o), 32'd1);
    chk("vid_adr_o", 32'(adr_o), 32'h7F8000);
    chk("vid_we_o", 32'(we_o), 32'd0);
    chk("vid_sel_o", 32'(sel_o), 32'd3);
    chk("vid_dat_o_zero", 32'(dat_o), 32'd0);
    ack_i = 1'b1;
    #1;
    chk("vid_ack_track", 32'(vid_ack_o), 32'd1);
    chk("cpu_ack_blocked", 32'(cpu_ack_o), 32'd0);
    chk("vid_dat_route", 32'(vid_dat_o), 32'h1234);
    ack_i = 1'b0;

    // V drops cyc: direct handoff to waiting C
    @(negedge clk_i);
    vid_cyc_i = 1'b0; vid_stb_i = 1'b0;
    @(negedge clk_i);
    chk("handoff_gnt_cpu", 32'(gnt_cpu_o), 32'd1);
    chk("handoff_gnt_vid", 32'(gnt_vid_o), 32'd0);
    chk("cpu_we_o", 32'(we_o), 32'd1);
    chk("cpu_adr_o", 32'(adr_o), 32'h000010);
    chk("cpu_dat_o_pass", 32'(dat_o), 32'hBEEF);
    chk("cpu_sel_o", 32'(sel_o), 32'd1);
    ack_i = 1'b1; dat_i = 16'h5A5A;
    #1;
    chk("cpu_ack", 32'(cpu_ack_o), 32'd1);
    chk("cpu_dat_route", 32'(cpu_dat_o), 32'h5A5A);
    @(negedge clk_i);
    chk("cpu_stays_alone", 32'(gnt_cpu_o), 32'd1);
    ack_i = 1'b0;
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    @(negedge clk_i);
    chk("idle_gnt", 32'({gnt_vid_o, gnt_cpu_o}), 32'd0);
    chk("idle_cyc_o", 32'(cyc_o), 32'd0);

    // starvation bound: V streams with C waiting
    vid_cyc_i = 1'b1; vid_stb_i = 1'b1;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    @(negedge clk_i);
    chk("burst_start_vid", 32'(gnt_vid_o), 32'd1);
    ack_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 30 && !gnt_cpu_o; i++) begin
      #1;
      if (vid_ack_o) acks++;
      @(negedge clk_i);
    end
    chk("burst_vid_acks", 32'(acks), 32'd8);
    chk("burst_gnt_cpu", 32'(gnt_cpu_o), 32'd1);
    chk("burst_cpu_we", 32'(we_o), 32'd1);
    chk("burst_cpu_dat", 32'(dat_o), 32'hBEEF);
    chk("burst_cpu_ack", 32'(cpu_ack_o), 32'd1);
    chk("burst_vid_ack_off", 32'(vid_ack_o), 32'd0);
    @(negedge clk_i);
    chk("return_to_vid", 32'(gnt_vid_o), 32'd1);

    // budget without contender: V keeps the bus for 20 acks
    @(negedge clk_i);
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    @(negedge clk_i);
    acks = 0; left_vid = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (vid_ack_o) acks++;
      if (!gnt_vid_o) left_vid++;
      @(negedge clk_i);
    end
    chk("solo_vid_acks", 32'(acks), 32'd20);
    chk("solo_never_left", 32'(left_vid), 32'd0);
    // late contender against a saturated budget wins at the next ack
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    @(negedge clk_i);
    chk("late_cpu_gnt", 32'(gnt_cpu_o), 32'd1);

    // asynchronous reset mid CPU transfer
    #2;
    reset_ni = 1'b0;
    #1;
    chk("arst_cyc_o", 32'(cyc_o), 32'd0);
    chk("arst_cpu_ack", 32'(cpu_ack_o), 32'd0);
    chk("arst_gnt", 32'({gnt_vid_o, gnt_cpu_o}), 32'd0);
    @(negedge clk_i);
    chk("arst_hold_idle", 32'({gnt_vid_o, gnt_cpu_o}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
